// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a counted little-endian byte image into instruction memory and holds the core in reset until the image is complete
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   start              one-cycle load request, honoured when not busy
//   in_valid/in_data   byte stream offer; in_ready accepts it
//   imem_we/addr/wdata one-cycle word write into instruction memory
//   core_hold          1 keeps the core in reset
//   busy/done/err      load status; words_loaded counts words written
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);
  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR} state_t;
  localparam logic [15:0] MAXW = 16'(MAX_WORDS);
  state_t      state;
  logic [15:0] count, word_idx, hdr;
  logic [1:0]  byte_idx;
  logic        xfer;
  assign xfer = in_valid & in_ready;
  assign hdr  = {in_data, count[7:0]};
  // in_ready is registered alongside every state change so it depends only on state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_hold    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      count        <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state        <= HDR_LO;
          in_ready     <= 1'b1;
          busy         <= 1'b1;
          done         <= 1'b0;
          err          <= 1'b0;
          core_hold    <= 1'b1;
          words_loaded <= '0;
          word_idx     <= '0;
        end
        HDR_LO: if (xfer) begin
          count[7:0] <= in_data;
          state      <= HDR_HI;
        end
        HDR_HI: if (xfer) begin
          count[15:8] <= in_data;
          if (hdr == 16'd0 || hdr > MAXW) begin
            state    <= ERR;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b1;
          end else begin
            state    <= DATA;
            byte_idx <= '0;
          end
        end
        DATA: if (xfer) begin
          imem_wdata[8*byte_idx +: 8] <= in_data;
          byte_idx                    <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            state     <= WRITE;
            in_ready  <= 1'b0;
            imem_we   <= 1'b1;
            imem_addr <= {word_idx[ADDR_W-3:0], 2'b00};
          end
        end
        WRITE: begin
          word_idx     <= word_idx + 16'd1;
          words_loaded <= words_loaded + 16'd1;
          byte_idx     <= '0;
          if (word_idx + 16'd1 == count) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            core_hold <= 1'b0;
          end else begin
            state    <= DATA;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized scoreboard bench for imem_boot_loader
module tb_imem_boot_loader;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, imem_we, core_hold, busy, done, err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] words_loaded;
  int          checks = 0, errors = 0;
  logic [41:0] exp_q[$];
  logic [31:0] words[$];
  logic [41:0] mon_e;

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(10), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst) begin
    chk("done_err_exclusive", {63'd0, done & err}, 64'd0);
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("imem_write", {22'd0, imem_addr, imem_wdata}, {22'd0, mon_e});
        chk("hold_during_write", {62'd0, core_hold, busy}, 64'd3);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // gap: 0 none, 1 one idle cycle per byte, 2 random 0..2 idle cycles
  task automatic send(input logic [7:0] b, input int gap, input bit noise);
    int g;
    g = gap == 2 ? int'($urandom_range(0, 2)) : gap;
    repeat (g) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (noise) start = $urandom_range(0, 2) == 0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 100; t++) begin
      if (noise) start = $urandom_range(0, 2) == 0;
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      tick();
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic load(input logic [15:0] cnt, input int gap, input bit noise);
    bit ok;
    int t;
    ok = cnt != 16'd0 && cnt <= 16'd256;
    exp_q.delete();
    pulse_start();
    send(cnt[7:0], gap, noise);
    send(cnt[15:8], gap, noise);
    if (ok) for (int i = 0; i < int'(cnt); i++) for (int b = 0; b < 4; b++) begin
      if (b == 3) exp_q.push_back({10'(4 * i), words[i]});
      send(words[i][8*b +: 8], gap, noise);
    end
    t = 0;
    while (!(done || err) && t < 40) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("status_done_err_hold_busy_rdy", {59'd0, done, err, core_hold, busy, in_ready},
        ok ? 64'b10000 : 64'b01100);
    chk("words_loaded", {48'd0, words_loaded}, ok ? {48'd0, cnt} : 64'd0);
    chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    logic [15:0] cnt;
    int r;
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("reset_state", {57'd0, core_hold, in_ready, imem_we, done, err, busy, |words_loaded}, 64'b1000000);
    tick();
    in_valid = 1'b1;
    repeat (10) begin
      in_data = 8'($urandom);
      @(negedge clk);
      chk("idle_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
    end
    in_valid = 1'b0;

    words = '{32'h00100513, 32'h00200593};
    load(16'd2, 0, 1'b0);

    load(16'd0, 0, 1'b0);
    words = '{32'($urandom)};
    load(16'd1, 0, 1'b0);

    load(16'd257, 0, 1'b0);

    words = '{32'($urandom)};
    load(16'd1, 1, 1'b1);

    words.delete();
    repeat (256) words.push_back(32'($urandom));
    load(16'd256, 0, 1'b0);

    words = '{32'($urandom) | 32'h0000_0101};
    exp_q.delete();
    pulse_start();
    send(8'd1, 0, 1'b0);
    send(8'd0, 0, 1'b0);
    send(words[0][7:0], 0, 1'b0);
    send(words[0][15:8], 0, 1'b0);
    rst = 1'b0;
    #1;
    chk("reset_mid_load", {in_ready, imem_we, imem_addr, imem_wdata, core_hold, busy, done, err, words_loaded},
        {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    tick();
    tick();
    rst = 1'b1;
    tick();
    load(16'd1, 2, 1'b0);

    for (int k = 0; k < 12; k++) begin
      r   = int'($urandom_range(0, 9));
      cnt = r == 0 ? 16'd0 : r == 1 ? 16'($urandom_range(257, 65535)) : 16'($urandom_range(1, 8));
      words.delete();
      if (cnt != 16'd0 && cnt <= 16'd8) repeat (int'(cnt)) words.push_back(32'($urandom));
      load(cnt, 2, bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time loader that sits directly upstream of the single-cycle core's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through its write port and holds the core in reset until the image is complete.
- Stream format: 16-bit little-endian word count, then count×4 instruction bytes.

Parameters:
- ADDR_W, 10, instruction-memory byte-address width.
- MAX_WORDS, 256, largest accepted word count; MAX_WORDS*4 must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid & in_ready at a clock edge.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  byte address of the word being written (word_idx*4).
- imem_wdata  output  32  assembled instruction word.
- core_hold  output  1  1 holds the core in reset.
- busy  output  1  load in progress.
- done  output  1  last load completed successfully.
- err  output  1  last load rejected.
- words_loaded  output  16  words written in the current or last load.

Behaviour:
- All outputs are registered. in_ready is a pure function of state, with no path from in_valid.
- Reset values (asynchronous, while rst=0): state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, busy=0, done=0, err=0, words_loaded=0, internal count/byte_idx/word_idx=0.
- State IDLE: in_ready=0.
  - start=1 → HDR_LO; set busy=1, clear done/err/words_loaded/word_idx.
- State HDR_LO: in_ready=1.
  - On transfer: count[7:0]=in_data → HDR_HI.
- State HDR_HI: in_ready=1.
  - On transfer: count[15:8]=in_data.
  - If the full count is 0 or > MAX_WORDS → ERR.
  - Otherwise → DATA with byte_idx=0.
- State DATA: in_ready=1.
  - On each transfer: imem_wdata[8*byte_idx+:8]=in_data, byte_idx++.
  - On the 4th byte (byte_idx==3) → WRITE; in_ready drops the following cycle.
- State WRITE: in_ready=0.
  - imem_we=1 for exactly one cycle with imem_addr=word_idx*4 and stable imem_wdata.
  - On leaving: word_idx++, words_loaded++, byte_idx=0.
  - If word_idx+1==count → DONE, otherwise → DATA.
- State DONE: busy=0, done=1, core_hold=0, in_ready=0.
  - start → HDR_LO; core_hold returns to 1 on that same edge.
- State ERR: busy=0, err=1, core_hold=1, in_ready=0.
  - start → HDR_LO.
  - Instruction memory contents are undefined; words already written are not erased.
- Throughput: minimum 5 cycles per word (4 byte transfers + 1 write). Header costs 2 transfers.
- Backpressure: in_valid may drop at any time. The state holds and no byte is consumed. Bytes offered when in_ready=0 are ignored and not stored.
- start while busy=1 is ignored.
- imem_addr wraps modulo 2^ADDR_W. This is unreachable given the MAX_WORDS constraint.
- Reset asserted mid-load aborts immediately to the reset values. core_hold stays 1 and a partial image remains in memory.
- imem_we never asserts outside WRITE.
- done and err are never both 1.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, release → core_hold=1, in_ready=0, imem_we=0, done=err=0; idle 10 cycles with in_valid=1 → no writes.
- Two-word load: start, stream 02 00 13 05 10 00 93 05 20 00 →
  - imem_we at addr 0 with 0x00100513, then addr 4 with 0x00200593;
  - then done=1, core_hold=0, words_loaded=2.
- Count zero: start, stream 00 00 → err=1, core_hold=1, no imem_we; then start with a valid 1-word image → done=1.
- Count overflow: header 01 01 (257) with MAX_WORDS=256 → err=1 after the 2nd byte, in_ready=0, no writes.
- Backpressure: 1-word image with in_valid toggling 1/0 each cycle → exactly one write of the correct word; start pulses during the load are ignored.
- Reset mid-load: rst=0 after 2 of 4 data bytes → all outputs at reset values within the same cycle; a subsequent full load succeeds.
